trivium_decryptor: RTL

// Receive-side counterpart of the Trivium stream encryptor. Loads the same 80-bit key

---
 rtl/trivium_decryptor.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/trivium_decryptor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : trivium_decryptor
// Description : Serial-key Trivium receiver; XORs each ciphertext byte with
//               8 keystream bits and streams plaintext in FIFO-paced blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_decryptor #(
    parameter int          BLOCK_BYTES = 256,
    parameter int          INIT_CYCLES = 1152,
    parameter logic [31:0] MAX_BYTES   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    input  logic        strob_key,
    input  logic [79:0] iv,
    input  logic [7:0]  data,
    input  logic        strob_data,
    input  logic [1:0]  fifo_cnd,
    output logic [7:0]  plain,
    output logic        plain_vld,
    output logic [7:0]  sign_reg
);

    typedef enum logic [2:0] {
        S_NOKEY     = 3'd0,
        S_GETKEY    = 3'd1,
        S_KEYOK     = 3'd2,
        S_INIT      = 3'd3,
        S_DECRYPT   = 3'd4,
        S_BLOCKDONE = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [8:0]  c_block_last = 9'(BLOCK_BYTES - 1);
    localparam logic [10:0] c_init_last  = 11'(INIT_CYCLES - 1);
    localparam logic [31:0] c_total_last = MAX_BYTES - 32'd1;
    localparam logic [6:0]  c_key_bits   = 7'd80;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_key;
    logic           r_strob_key;
    logic [7:0]     r_data;
    logic           r_strob_data;
    logic [1:0]     r_fifo_cnd;

    logic [79:0]    r_key_reg;
    logic [6:0]     r_key_cnt;
    logic [6:0]     w_key_cnt_inc;
    logic [287:0]   r_s;
    logic [10:0]    r_init_cnt;
    logic [8:0]     r_block_cnt;
    logic [31:0]    r_total;
    logic           r_overrun;
    logic           r_key_loaded;

    logic           w_accept;
    logic           w_overrun_set;
    logic           w_key_shift;
    logic           w_load;
    logic           w_init_step;
    logic [287:0]   w_s_load;
    logic [287:0]   w_s_byte;
    logic [7:0]     w_ks;

    // s[i-1] holds Trivium bit s_i: A = s[92:0], B = s[176:93], C = s[287:177]
    function automatic logic f_z(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [287:0] f_next(input logic [287:0] s);
        logic t1;
        logic t2;
        logic t3;
        t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    always_comb begin
        w_s_byte = r_s;
        w_ks     = '0;
        for (int i = 0; i < 8; i++) begin
            w_ks[i]  = f_z(w_s_byte);
            w_s_byte = f_next(w_s_byte);
        end
    end

    // First key bit received (k1) and iv[79] land in s1 and s94 respectively
    always_comb begin
        w_s_load = '0;
        for (int i = 0; i < 80; i++) begin
            w_s_load[i]      = r_key_reg[79-i];
            w_s_load[93 + i] = iv[79-i];
        end
        w_s_load[287:285] = 3'b111;
    end

    assign w_key_cnt_inc = (r_key_cnt == 7'h7F) ? r_key_cnt : r_key_cnt + 7'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_NOKEY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_overrun_set = 1'b0;
        w_key_shift   = 1'b0;
        w_load        = 1'b0;
        w_init_step   = 1'b0;
        case (r_state)
            S_NOKEY: begin
                if (r_strob_key) begin
                    w_state_next = S_GETKEY;
                    w_key_shift  = 1'b1;
                end else if (r_strob_data) begin
                    w_state_next = S_ERROR;
                end
            end
            S_GETKEY: begin
                if (r_strob_key) begin
                    w_key_shift = 1'b1;
                end else if (r_key_cnt == c_key_bits) begin
                    w_state_next = S_KEYOK;
                end else begin
                    w_state_next = S_ERROR;
                end
            end
            S_KEYOK: begin
                w_load       = 1'b1;
                w_state_next = r_strob_data ? S_ERROR : S_INIT;
            end
            S_INIT: begin
                if (r_strob_data) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_init_step = 1'b1;
                    if (r_init_cnt == c_init_last) begin
                        w_state_next = S_DECRYPT;
                    end
                end
            end
            S_DECRYPT: begin
                if (r_strob_key) begin
                    w_state_next = S_GETKEY;
                    w_key_shift  = 1'b1;
                end else if (r_strob_data) begin
                    if (r_fifo_cnd == 2'b11) begin
                        w_overrun_set = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        if (r_total == c_total_last) begin
                            w_state_next = S_NOKEY;
                        end else if (r_block_cnt == c_block_last) begin
                            w_state_next = S_BLOCKDONE;
                        end
                    end
                end
            end
            S_BLOCKDONE: begin
                if (r_strob_key) begin
                    w_state_next = S_GETKEY;
                    w_key_shift  = 1'b1;
                end else if (r_strob_data) begin
                    w_state_next = S_ERROR;
                end else if (r_fifo_cnd == 2'b00) begin
                    w_state_next = S_DECRYPT;
                end
            end
            S_ERROR: begin
                if (r_strob_key) begin
                    w_state_next = S_GETKEY;
                    w_key_shift  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_NOKEY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key        <= 1'b0;
            r_strob_key  <= 1'b0;
            r_data       <= '0;
            r_strob_data <= 1'b0;
            r_fifo_cnd   <= '0;
            r_key_reg    <= '0;
            r_key_cnt    <= '0;
            r_s          <= '0;
            r_init_cnt   <= '0;
            r_block_cnt  <= '0;
            r_total      <= '0;
            r_overrun    <= 1'b0;
            r_key_loaded <= 1'b0;
            plain        <= '0;
            plain_vld    <= 1'b0;
            sign_reg     <= '0;
        end else begin
            r_key        <= key;
            r_strob_key  <= strob_key;
            r_data       <= data;
            r_strob_data <= strob_data;
            r_fifo_cnd   <= fifo_cnd;

            // A fresh key load restarts the bit count from whatever state it interrupts
            if (w_key_shift) begin
                r_key_reg <= {r_key_reg[78:0], r_key};
                r_key_cnt <= (r_state == S_GETKEY) ? w_key_cnt_inc : 7'd1;
            end

            if (w_load) begin
                r_s <= w_s_load;
            end else if (w_init_step) begin
                r_s <= f_next(r_s);
            end else if (w_accept) begin
                r_s <= w_s_byte;
            end

            if (w_load) begin
                r_init_cnt  <= '0;
                r_block_cnt <= '0;
                r_total     <= '0;
            end else begin
                if (w_init_step) begin
                    r_init_cnt <= r_init_cnt + 11'd1;
                end
                if (w_accept) begin
                    r_block_cnt <= r_block_cnt + 9'd1;
                    r_total     <= r_total + 32'd1;
                end else if (r_state == S_BLOCKDONE) begin
                    r_block_cnt <= '0;
                end
            end

            if (w_load) begin
                r_overrun <= 1'b0;
            end else if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end

            if (w_load) begin
                r_key_loaded <= 1'b1;
            end else if (w_state_next == S_GETKEY || w_state_next == S_ERROR ||
                         w_state_next == S_NOKEY) begin
                r_key_loaded <= 1'b0;
            end

            plain_vld <= w_accept;
            if (w_accept) begin
                plain <= r_data ^ w_ks;
            end else if (r_state == S_BLOCKDONE) begin
                plain <= '0;
            end

            sign_reg <= {3'b000, r_key_loaded, r_overrun, (r_state == S_ERROR),
                         (r_state == S_BLOCKDONE), (r_state == S_DECRYPT)};
        end
    end

endmodule
`default_nettype wire
